// File: rtl/decode_hazard_control.sv
// decode_hazard_control
// Register-read stage control for a five-stage pipeline (IF, RF, EX, MEM, WB).
// It decides each cycle whether the instruction in IR1 may advance into IR2.
// When it cannot, it stalls fetch and puts a bubble into IR2.
// It also owns the IR2..IR5 instruction/valid registers and a saturating
// count of stall cycles.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   ir1, ir1_valid      fetched instruction {R2[7:6], R1[5:4], opcode[3:0]}
//   flush               taken branch resolved in EX; squashes IR1 into IR2
//   stall               combinational hold request to fetch
//   ir2..ir5, v2..v5    stage instruction registers and valid bits
//   rf_raddr1/2         register-file read addresses, taken from IR2
//   rf_we, rf_waddr     register-file write port, taken from IR5
//   stall_count         saturating number of stalled cycles
module decode_hazard_control #(
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned IR_W  = 8,
   localparam int unsigned RA_W  = 2,
   localparam int unsigned OP_W  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IR_W-1:0]  ir1,
   input  logic             ir1_valid,
   input  logic             flush,
   output logic             stall,
   output logic [IR_W-1:0]  ir2,
   output logic [IR_W-1:0]  ir3,
   output logic [IR_W-1:0]  ir4,
   output logic [IR_W-1:0]  ir5,
   output logic             v2,
   output logic             v3,
   output logic             v4,
   output logic             v5,
   output logic [RA_W-1:0]  rf_raddr1,
   output logic [RA_W-1:0]  rf_raddr2,
   output logic             rf_we,
   output logic [RA_W-1:0]  rf_waddr,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [OP_W-1:0]  OP_LOAD  = 4'b0000;
   localparam logic [OP_W-1:0]  OP_STORE = 4'b0010;
   localparam logic [OP_W-1:0]  OP_ADD   = 4'b0100;
   localparam logic [OP_W-1:0]  OP_SUB   = 4'b0110;
   localparam logic [OP_W-1:0]  OP_NAND  = 4'b1000;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Opcode class decoders; every unlisted opcode reads and writes nothing
   function automatic logic is_writer(input logic [OP_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND);
   endfunction

   function automatic logic reads_r1(input logic [OP_W-1:0] op);
      return (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND);
   endfunction

   function automatic logic reads_r2(input logic [OP_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_NAND);
   endfunction

   logic            wr2;
   logic            wr3;
   logic [RA_W-1:0] src1;
   logic [RA_W-1:0] src2;
   logic            hit1;
   logic            hit2;
   logic            hazard;

   // Producers still in RF or EX. A writer in MEM (IR4) has already written
   // back by the time the dependent instruction reaches IR2, because the
   // register file writes in the first half of the cycle.
   assign wr2  = v2 && is_writer(ir2[OP_W-1:0]);
   assign wr3  = v3 && is_writer(ir3[OP_W-1:0]);
   assign src1 = ir1[5:4];
   assign src2 = ir1[7:6];
   assign hit1 = (wr2 && (ir2[5:4] == src1)) || (wr3 && (ir3[5:4] == src1));
   assign hit2 = (wr2 && (ir2[5:4] == src2)) || (wr3 && (ir3[5:4] == src2));

   // A double read of one register is still a single hazard
   assign hazard = ir1_valid &&
                   ((reads_r1(ir1[OP_W-1:0]) && hit1) || (reads_r2(ir1[OP_W-1:0]) && hit2));

   // A flush squashes IR1 anyway, so holding it would be pointless
   assign stall = hazard && !flush;

   // Register-file ports
   assign rf_raddr1 = ir2[5:4];
   assign rf_raddr2 = ir2[7:6];
   assign rf_we     = v5 && is_writer(ir5[OP_W-1:0]);
   assign rf_waddr  = ir5[5:4];

   // Pipeline registers and stall counter
   always_ff @(posedge clock) begin
      if (!reset) begin
         ir2         <= '0;
         ir3         <= '0;
         ir4         <= '0;
         ir5         <= '0;
         v2          <= 1'b0;
         v3          <= 1'b0;
         v4          <= 1'b0;
         v5          <= 1'b0;
         stall_count <= '0;
      end else begin
         // Downstream stages never hold
         ir3 <= ir2;
         ir4 <= ir3;
         ir5 <= ir4;
         v3  <= v2;
         v4  <= v3;
         v5  <= v4;

         // On flush or stall only the valid bit drops; ir2 keeps stale contents
         if (flush || stall) begin
            v2 <= 1'b0;
         end else begin
            ir2 <= ir1;
            v2  <= ir1_valid;
         end

         if (stall && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_hazard_control.sv
module tb_decode_hazard_control;

   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_SAT = 15;

   localparam logic [3:0] LOAD  = 4'b0000;
   localparam logic [3:0] STORE = 4'b0010;
   localparam logic [3:0] ADD   = 4'b0100;
   localparam logic [3:0] SUB   = 4'b0110;
   localparam logic [3:0] NAND  = 4'b1000;

   logic             clock;
   logic             reset;
   logic [7:0]       ir1;
   logic             ir1_valid;
   logic             flush;
   logic             stall;
   logic [7:0]       ir2, ir3, ir4, ir5;
   logic             v2, v3, v4, v5;
   logic [1:0]       rf_raddr1, rf_raddr2;
   logic             rf_we;
   logic [1:0]       rf_waddr;
   logic [CNT_W-1:0] stall_count;

   decode_hazard_control #(.CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .ir1         (ir1),
      .ir1_valid   (ir1_valid),
      .flush       (flush),
      .stall       (stall),
      .ir2         (ir2),
      .ir3         (ir3),
      .ir4         (ir4),
      .ir5         (ir5),
      .v2          (v2),
      .v3          (v3),
      .v4          (v4),
      .v5          (v5),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .stall_count (stall_count)
   );

   typedef struct {
      logic [7:0] ir;
      logic       we;
      int         cyc;
   } ret_t;

   ret_t retire_q[$];
   logic stall_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int exp_cnt = 0;
   logic mon_en = 1'b0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [7:0] mk(input logic [3:0] op, input logic [1:0] r1,
                                     input logic [1:0] r2);
      return {r2, r1, op};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: per-cycle stall expectation, and in-order retirement at IR5
   always @(negedge clock) begin
      if (mon_en) begin
         if (stall_q.size() > 0) check("stall", 32'(stall), 32'(stall_q.pop_front()));
         if (v5) begin
            if (retire_q.size() == 0) begin
               check("unexpected_retire", 32'(ir5), 32'hFFFF_FFFF);
            end else begin
               ret_t e;
               e = retire_q.pop_front();
               check("ir5", 32'(ir5), 32'(e.ir));
               check("rf_we", 32'(rf_we), 32'(e.we));
               check("rf_waddr", 32'(rf_waddr), 32'(e.ir[5:4]));
               check("retire_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   // One RF-stage cycle with hand-computed expected stall and writer flag
   task automatic step(input logic [7:0] ir, input logic vld, input logic fl,
                       input logic exp_st, input logic exp_we);
      logic issue;
      ret_t r;
      issue = vld && !fl && !exp_st;
      ir1 = ir;
      ir1_valid = vld;
      flush = fl;
      stall_q.push_back(exp_st);
      if (issue) begin
         r.ir  = ir;
         r.we  = exp_we;
         r.cyc = cyc + 4;
         retire_q.push_back(r);
      end
      if (exp_st && exp_cnt != CNT_SAT) exp_cnt++;
      @(posedge clock);
      #1;
      check("v2", 32'(v2), 32'(issue));
      if (issue) begin
         check("ir2", 32'(ir2), 32'(ir));
         check("rf_raddr1", 32'(rf_raddr1), 32'(ir[5:4]));
         check("rf_raddr2", 32'(rf_raddr2), 32'(ir[7:6]));
      end
      check("stall_count", 32'(stall_count), 32'(exp_cnt));
   endtask

   task automatic drain(input int n);
      repeat (n) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_v2"}, 32'(v2), 0);
      check({tag, "_v3"}, 32'(v3), 0);
      check({tag, "_v4"}, 32'(v4), 0);
      check({tag, "_v5"}, 32'(v5), 0);
      check({tag, "_ir5"}, 32'(ir5), 0);
      check({tag, "_stall"}, 32'(stall), 0);
      check({tag, "_rf_we"}, 32'(rf_we), 0);
      check({tag, "_count"}, 32'(stall_count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held two cycles while IR1 holds a valid instruction
      reset = 1'b0;
      ir1 = mk(ADD, 2'd1, 2'd2);
      ir1_valid = 1'b1;
      flush = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_cleared("reset");
      reset = 1'b1;
      mon_en = 1'b1;
      step(mk(ADD, 2'd1, 2'd2), 1'b1, 1'b0, 1'b0, 1'b1);
      drain(5);

      // Independent stream
      step(mk(ADD, 2'd1, 2'd2), 1'b1, 1'b0, 1'b0, 1'b1);
      step(mk(ADD, 2'd3, 2'd0), 1'b1, 1'b0, 1'b0, 1'b1);
      drain(5);

      // RAW on IR2 producer: two bubbles
      step(mk(ADD, 2'd1, 2'd2), 1'b1, 1'b0, 1'b0, 1'b1);
      step(mk(SUB, 2'd3, 2'd1), 1'b1, 1'b0, 1'b1, 1'b0);
      step(mk(SUB, 2'd3, 2'd1), 1'b1, 1'b0, 1'b1, 1'b0);
      step(mk(SUB, 2'd3, 2'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      drain(5);
      check("count_after_raw_ir2", 32'(stall_count), 2);

      // RAW on IR3 producer: one bubble
      step(mk(LOAD,  2'd2, 2'd0), 1'b1, 1'b0, 1'b0, 1'b1);
      step(mk(NAND,  2'd0, 2'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      step(mk(STORE, 2'd2, 2'd3), 1'b1, 1'b0, 1'b1, 1'b0);
      step(mk(STORE, 2'd2, 2'd3), 1'b1, 1'b0, 1'b0, 1'b0);
      drain(5);
      check("count_after_raw_ir3", 32'(stall_count), 3);

      // Flush beats hazard, then a double-read dependency counts once
      step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b1, 1'b0, 1'b1);
      step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b1, 1'b1);
      step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      drain(5);
      check("count_after_flush", 32'(stall_count), 4);

      // Saturation: chain of dependent ADDs, 20 stall cycles
      step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b1, 1'b1);
         step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b1, 1'b1);
         step(mk(ADD, 2'd1, 2'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      end
      drain(5);
      check("count_saturated", 32'(stall_count), CNT_SAT);

      // Mid-operation reset discards in-flight instructions
      ir1 = mk(ADD, 2'd2, 2'd3);
      ir1_valid = 1'b1;
      flush = 1'b0;
      @(posedge clock);
      #1;
      ir1 = mk(NAND, 2'd3, 2'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      ir1_valid = 1'b0;
      @(posedge clock);
      #1;
      check_cleared("midreset");
      reset = 1'b1;
      exp_cnt = 0;
      drain(6);

      check("retire_queue_empty", 32'(retire_q.size()), 0);
      check("stall_queue_empty", 32'(stall_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_hazard_control.md
# decode_hazard_control

Register-read (RF) stage control for the five-stage pipeline (IF → RF → EX → MEM → WB), directly downstream of fetch control. Accepts the fetched instruction from IR1, decides each cycle whether it may advance into IR2 or must be held, and returns a stall to fetch. On a hazard it inserts a bubble. It owns the IR2–IR5 instruction and valid registers and drives register-file read/write control and a stall-cycle counter.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- ir1  in  8  instruction in IR1: [3:0] opcode, [5:4] R1, [7:6] R2
- ir1_valid  in  1  IR1 holds a real instruction
- flush  in  1  taken branch resolved in EX; squash IR1/IR2 contents
- stall  out  1  hold PC and IR1 this cycle (combinational)
- ir2, ir3, ir4, ir5  out  8 each  stage instruction registers
- v2, v3, v4, v5  out  1 each  stage valid bits
- rf_raddr1, rf_raddr2  out  2 each  ir2[5:4], ir2[7:6]
- rf_we  out  1  v5 and ir5 is a writer
- rf_waddr  out  2  ir5[5:4]
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Opcode classes:
  - 0000 LOAD: reads R2, writes R1.
  - 0010 STORE: reads R1, R2; no write.
  - 0100 ADD, 0110 SUB, 1000 NAND: read R1, R2; write R1.
  - 0001 BRANCH and all other codes: no register reads, no writes.
- Register file writes in WB (IR5) before the read in RF (IR2) in the same cycle. No forwarding.
- Hazard: ir1_valid and IR1 reads register r, and (v2 and ir2 writer with ir2[5:4]==r) or (v3 and ir3 writer with ir3[5:4]==r).
  - A writer in IR4 is not a hazard; it writes back when IR1's instruction reaches IR2.
- stall = hazard and not flush.
- Every cycle, IR3←IR2, IR4←IR3, IR5←IR4 with their valids, unconditionally. This stage never back-pressures downstream.
- IR2 load, in priority order:
  1. flush: v2←0.
  2. stall: v2←0 (bubble). IR1 is held by fetch.
  3. otherwise: ir2←ir1, v2←ir1_valid.
- When v2 becomes 0, ir2 contents may be left unchanged. Consumers must qualify with the valid bit.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.
- rf_we/rf_waddr are combinational from the IR5 registers. rf_raddr1/2 are combinational from IR2.

## Timing
- Reset (reset=0 at a rising edge):
  - v2..v5←0, ir2..ir5←8'h00, stall_count←0.
  - Resulting outputs: stall=0, rf_we=0.
  - Reset mid-operation discards all in-flight instructions in that edge.
- Latency: an unstalled instruction appears in IR2 one cycle after it is in IR1, and in IR5 four cycles after.
- Stall depth:
  - Dependent on IR2 producer: 2 stall cycles.
  - Dependent on IR3 producer: 1 stall cycle.
  - Back-to-back dependency: adjacent ADD R1→ADD R1 gives exactly 2 bubbles.
- stall depends only on registered state plus ir1/ir1_valid/flush. There is no path through the block's own next-state.
- Simultaneous flush and hazard: flush wins, stall=0, bubble into IR2, and stall_count does not increment.
- ir1_valid=0: no hazard is possible and a bubble enters IR2.
- An instruction that reads the same register twice raises stall once and counts once per cycle.
- Counter wrap: none. It holds at 2^CNT_W−1.

## Test plan
- Reset: hold reset=0 for 2 cycles with ir1_valid=1 → v2..v5=0, stall=0, rf_we=0, stall_count=0. Release and feed ADD R1=1,R2=2 → v2=1 next cycle.
- Independent stream: ADD r1,r2 then ADD r3,r0, consecutive → stall=0 throughout. After 4 cycles rf_we=1 with rf_waddr=1, then rf_waddr=3.
- RAW on IR2: ADD r1,r2 then SUB r3,r1 → stall=1 for 2 cycles, two bubbles (v2=0), stall_count=2. SUB then enters IR2 in the same cycle the ADD is in IR5 (rf_we=1, rf_waddr=1).
- RAW on IR3: LOAD r2,[r0], NAND r0,r1, STORE r2,r3 → 1 stall cycle before STORE enters IR2, stall_count=1.
- Flush vs hazard: ADD r1,r1 then ADD r1,r1, with flush=1 on the first stall cycle → stall=0 that cycle, v2=0 next, stall_count unchanged.
- Saturation: CNT_W=4, force a continuous hazard for 20 cycles (repeat dependent pairs) → stall_count holds at 15.
